exu_lsu: RTL and testbench

EXU_LSU -- requirements
Module: exu_lsu

---
 rtl/exu_lsu_pkg.sv | 34 +++
 rtl/MuxKeyWithDefault.sv | 31 +++
 rtl/config.vh | 19 +
 rtl/exu_lsu_align.sv | 44 ++++
 rtl/exu_lsu.sv | 161 ++++++++++++++++
 tb/tb_exu_lsu.sv | 195 +++++++++++++++++++
 6 files changed

// File: rtl/exu_lsu_pkg.sv
// Types, constants and helpers shared by the load/store unit files.
`include "config.vh"

package exu_lsu_pkg;

  localparam int ISA_W = `ISA_WIDTH;
  localparam int ST_W  = `LSU_STATE_WIDTH;

  typedef enum logic [`LSU_STATE_WIDTH-1:0] {
    S_IDLE = `LSU_ST_IDLE,
    S_REQ  = `LSU_ST_REQ,
    S_WAIT = `LSU_ST_WAIT,
    S_DONE = `LSU_ST_DONE,
    S_ERR  = `LSU_ST_ERR
  } lsu_state_e;

  localparam logic [1:0] SZ_B = `LSU_SIZE_B;
  localparam logic [1:0] SZ_H = `LSU_SIZE_H;
  localparam logic [1:0] SZ_W = `LSU_SIZE_W;

  // An access is misaligned when it does not sit on its natural boundary;
  // the unused size code is always treated as an error.
  function automatic logic lsu_misaligned(input logic [1:0] i_sz, input logic [1:0] i_off);
    logic r;
    case (i_sz)
      SZ_B:    r = 1'b0;
      SZ_H:    r = i_off[0];
      SZ_W:    r = (i_off != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/MuxKeyWithDefault.sv
// Generic key/value lookup mux. Each lut entry is {key, data}; the output is
// the data of the entry whose key matches, or i_default when none matches.
module MuxKeyWithDefault #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  output logic [DATA_LEN-1:0]                  o_out,
  input  logic [KEY_LEN-1:0]                   i_key,
  input  logic [DATA_LEN-1:0]                  i_default,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] i_lut
);

  localparam int PAIR = KEY_LEN + DATA_LEN;

  logic [DATA_LEN-1:0] w_acc;
  logic                w_hit;

  // OR together the data of every matching entry, fall back to the default.
  always_comb begin
    w_acc = {DATA_LEN{1'b0}};
    w_hit = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      w_hit = w_hit | (i_lut[i*PAIR+DATA_LEN +: KEY_LEN] == i_key);
      w_acc = w_acc | ((i_lut[i*PAIR+DATA_LEN +: KEY_LEN] == i_key) ?
                       i_lut[i*PAIR +: DATA_LEN] : {DATA_LEN{1'b0}});
    end
    o_out = w_hit ? w_acc : i_default;
  end

endmodule

// File: rtl/config.vh
// Shared configuration constants for the load/store unit: datapath width,
// FSM state encodings and access-size codes.
`ifndef EXU_LSU_CONFIG_VH
`define EXU_LSU_CONFIG_VH

`define ISA_WIDTH       32

`define LSU_STATE_WIDTH 3
`define LSU_ST_IDLE     3'd0
`define LSU_ST_REQ      3'd1
`define LSU_ST_WAIT     3'd2
`define LSU_ST_DONE     3'd3
`define LSU_ST_ERR      3'd4

`define LSU_SIZE_B      2'd0
`define LSU_SIZE_H      2'd1
`define LSU_SIZE_W      2'd2

`endif

// File: rtl/exu_lsu_align.sv
// Byte-lane alignment for the load/store unit: builds the store byte mask
// and replicated store data, and right-justifies load data.
module exu_lsu_align
  import exu_lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  // Place store data on every lane it could occupy; the mask selects one.
  always_comb begin
    o_wmask = 4'b0000;
    o_wdata = 32'h0000_0000;
    case (i_size)
      SZ_B: begin
        o_wmask = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_wmask = 4'b0011 << i_off;
        o_wdata = {2{i_wdata[15:0]}};
      end
      SZ_W: begin
        o_wmask = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_wmask = 4'b0000;
        o_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Shift the addressed byte down to bit 0; upper bits fill with zero.
  always_comb begin
    o_rdata = i_rdata >> {i_off, 3'b000};
  end

endmodule

// File: rtl/exu_lsu.sv
// Load/store unit: accepts one memory operation at a time, issues a single
// request/response transaction on the memory port and reports completion
// with a one-cycle done pulse (err marks alignment faults and timeouts).
`include "config.vh"

module exu_lsu
  import exu_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [1:0]            size,
  input  logic [`ISA_WIDTH-1:0] addr,
  input  logic [`ISA_WIDTH-1:0] wdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [`ISA_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_rdata,
  output logic [`ISA_WIDTH-1:0] mem_r,
  output logic                  done,
  output logic                  err
);

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  lsu_state_e       r_state;
  logic [ISA_W-1:0] r_addr;
  logic [31:0]      r_wdata;
  logic [1:0]       r_size;
  logic             r_is_store;
  logic [7:0]       r_cnt;
  logic [ISA_W-1:0] r_mem_r;

  logic             w_take;
  logic             w_misal;
  logic             w_timeout;
  logic [ST_W-1:0]  w_idle_nxt;
  logic [ST_W-1:0]  w_req_nxt;
  logic [ST_W-1:0]  w_wait_nxt;
  logic [ST_W-1:0]  w_nxt;
  logic [3:0]       w_ctrl;
  logic [3:0]       w_al_wmask;
  logic [31:0]      w_al_wdata;
  logic [31:0]      w_al_rdata;
  logic [5*(ST_W+ST_W)-1:0] w_ns_lut;
  logic [5*(ST_W+4)-1:0]    w_out_lut;

  assign w_take    = req_valid & (is_load ^ is_store);
  assign w_misal   = lsu_misaligned(size, addr[1:0]);
  assign w_timeout = (({1'b0, r_cnt} + 9'd1) == TO_LIM);

  // Per-state next-state candidates, selected below by the current state.
  always_comb begin
    w_idle_nxt = S_IDLE;
    w_req_nxt  = S_REQ;
    w_wait_nxt = S_WAIT;
    if (w_take && w_misal) w_idle_nxt = S_ERR;
    else if (w_take)       w_idle_nxt = S_REQ;
    else                   w_idle_nxt = S_IDLE;
    if (mem_req_ready) w_req_nxt = S_WAIT;
    else               w_req_nxt = S_REQ;
    if (mem_resp_valid) w_wait_nxt = S_DONE;
    else if (w_timeout) w_wait_nxt = S_ERR;
    else                w_wait_nxt = S_WAIT;
  end

  assign w_ns_lut = {S_IDLE, w_idle_nxt,
                     S_REQ,  w_req_nxt,
                     S_WAIT, w_wait_nxt,
                     S_DONE, S_IDLE,
                     S_ERR,  S_IDLE};

  // Control outputs per state: {req_ready, mem_req_valid, done, err}.
  assign w_out_lut = {S_IDLE, 4'b1000,
                      S_REQ,  4'b0100,
                      S_WAIT, 4'b0000,
                      S_DONE, 4'b0010,
                      S_ERR,  4'b0011};

  MuxKeyWithDefault #(.NR_KEY(5), .KEY_LEN(ST_W), .DATA_LEN(ST_W)) u_ns_mux (
    .o_out     (w_nxt),
    .i_key     (r_state),
    .i_default (S_IDLE),
    .i_lut     (w_ns_lut)
  );

  MuxKeyWithDefault #(.NR_KEY(5), .KEY_LEN(ST_W), .DATA_LEN(4)) u_out_mux (
    .o_out     (w_ctrl),
    .i_key     (r_state),
    .i_default (4'b0000),
    .i_lut     (w_out_lut)
  );

  exu_lsu_align u_align (
    .i_size  (r_size),
    .i_off   (r_addr[1:0]),
    .i_wdata (r_wdata),
    .i_rdata (mem_rdata),
    .o_wmask (w_al_wmask),
    .o_wdata (w_al_wdata),
    .o_rdata (w_al_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= lsu_state_e'(w_nxt);
  end

  // Operation latch, wait counter and load-result register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr     <= {ISA_W{1'b0}};
      r_wdata    <= 32'h0000_0000;
      r_size     <= 2'b00;
      r_is_store <= 1'b0;
      r_cnt      <= 8'd0;
      r_mem_r    <= {ISA_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_addr     <= addr;
            r_wdata    <= wdata[31:0];
            r_size     <= size;
            r_is_store <= is_store;
          end
        end
        S_REQ: r_cnt <= 8'd0;
        S_WAIT: begin
          if (mem_resp_valid) begin
            if (!r_is_store) r_mem_r <= ISA_W'(w_al_rdata);
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = w_ctrl[3];
  assign mem_req_valid = w_ctrl[2];
  assign done          = w_ctrl[1];
  assign err           = w_ctrl[0];
  assign mem_wen       = w_ctrl[2] & r_is_store;
  assign mem_wmask     = mem_wen ? w_al_wmask : 4'b0000;
  assign mem_wdata     = w_al_wdata;
  assign mem_addr      = {r_addr[ISA_W-1:2], 2'b00};
  assign mem_r         = r_mem_r;

endmodule

// File: tb/tb_exu_lsu.sv
// Directed testbench for exu_lsu (instantiated with TIMEOUT=4).
module tb_exu_lsu;
  import exu_lsu_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, is_load, is_store;
  logic [1:0]       size;
  logic [ISA_W-1:0] addr, wdata, mem_addr, mem_r;
  logic             mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0]      mem_wdata, mem_rdata;
  logic [3:0]       mem_wmask;
  logic             mem_resp_valid, done, err;

  int n_chk  = 0;
  int n_fail = 0;

  exu_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .size(size), .addr(addr), .wdata(wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .mem_r(mem_r), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operation for exactly one edge; returns in cycle 1 after accept.
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; is_load = ld; is_store = st; size = sz; addr = a; wdata = wd;
    tick();
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  // Advance until done, bounded; returns the cycle number at which done was seen.
  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (done !== 1'b1 && cyc < start + 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    n_chk++; if (req_ready !== 1'b1) begin $display("FAIL reset_req_ready: got %b want 1", req_ready); n_fail++; end
    n_chk++; if ({done, err, mem_req_valid, mem_wen} !== 4'b0000) begin $display("FAIL reset_ctrl: got %b want 0000", {done, err, mem_req_valid, mem_wen}); n_fail++; end
    n_chk++; if (mem_wmask !== 4'b0000) begin $display("FAIL reset_wmask: got %b want 0000", mem_wmask); n_fail++; end
    n_chk++; if (mem_r !== 32'h0) begin $display("FAIL reset_mem_r: got %h want 00000000", mem_r); n_fail++; end
    rst = 1'b1;
  endtask

  task automatic test_word_load();
    int cyc;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    issue(1'b1, 1'b0, SZ_W, 32'h8000_0004, 32'h0);
    n_chk++; if ({req_ready, mem_req_valid, mem_wen} !== 3'b010) begin $display("FAIL wl_req_ctrl: got %b want 010", {req_ready, mem_req_valid, mem_wen}); n_fail++; end
    n_chk++; if (mem_addr !== 32'h8000_0004) begin $display("FAIL wl_addr: got %h want 80000004", mem_addr); n_fail++; end
    n_chk++; if (mem_wmask !== 4'b0000) begin $display("FAIL wl_wmask: got %b want 0000", mem_wmask); n_fail++; end
    wait_done(1, cyc);
    n_chk++; if (cyc !== 3) begin $display("FAIL wl_latency: got %0d want 3", cyc); n_fail++; end
    n_chk++; if (err !== 1'b0) begin $display("FAIL wl_err: got %b want 0", err); n_fail++; end
    n_chk++; if (mem_r !== 32'hDEADBEEF) begin $display("FAIL wl_mem_r: got %h want deadbeef", mem_r); n_fail++; end
    tick();
    n_chk++; if ({req_ready, done} !== 2'b10) begin $display("FAIL wl_idle: got %b want 10", {req_ready, done}); n_fail++; end
  endtask

  task automatic test_store_patterns();
    logic [1:0]  sz_v[3] = '{SZ_B, SZ_H, SZ_W};
    logic [31:0] a_v[3]  = '{32'h8000_0003, 32'h8000_0002, 32'h8000_0008};
    logic [31:0] d_v[3]  = '{32'h0000_00A5, 32'h0000_BEEF, 32'h1234_5678};
    logic [3:0]  m_e[3]  = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] d_e[3]  = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'h1234_5678};
    logic [31:0] a_e[3]  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0008};
    int cyc;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, sz_v[i], a_v[i], d_v[i]);
      n_chk++; if (mem_wen !== 1'b1) begin $display("FAIL st%0d_wen: got %b want 1", i, mem_wen); n_fail++; end
      n_chk++; if (mem_wmask !== m_e[i]) begin $display("FAIL st%0d_wmask: got %b want %b", i, mem_wmask, m_e[i]); n_fail++; end
      n_chk++; if (mem_wdata !== d_e[i]) begin $display("FAIL st%0d_wdata: got %h want %h", i, mem_wdata, d_e[i]); n_fail++; end
      n_chk++; if (mem_addr !== a_e[i]) begin $display("FAIL st%0d_addr: got %h want %h", i, mem_addr, a_e[i]); n_fail++; end
      wait_done(1, cyc);
      n_chk++; if (cyc !== 3 || err !== 1'b0) begin $display("FAIL st%0d_done: got cyc %0d err %b want cyc 3 err 0", i, cyc, err); n_fail++; end
      n_chk++; if (mem_r !== 32'hDEADBEEF) begin $display("FAIL st%0d_mem_r: got %h want deadbeef", i, mem_r); n_fail++; end
      tick();
    end
  endtask

  task automatic test_stall_half_load();
    int cyc;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h1234_ABCD;
    issue(1'b1, 1'b0, SZ_H, 32'h8000_0002, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      n_chk++; if ({mem_req_valid, mem_wen, mem_wmask, done} !== 7'b1000000) begin $display("FAIL stall%0d_ctrl: got %b want 1000000", i, {mem_req_valid, mem_wen, mem_wmask, done}); n_fail++; end
      n_chk++; if (mem_addr !== 32'h8000_0000) begin $display("FAIL stall%0d_addr: got %h want 80000000", i, mem_addr); n_fail++; end
      tick();
    end
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    n_chk++; if (mem_req_valid !== 1'b1) begin $display("FAIL stall5_valid: got %b want 1", mem_req_valid); n_fail++; end
    wait_done(5, cyc);
    n_chk++; if (cyc !== 7) begin $display("FAIL hl_latency: got %0d want 7", cyc); n_fail++; end
    n_chk++; if (mem_r !== 32'h0000_1234) begin $display("FAIL hl_mem_r: got %h want 00001234", mem_r); n_fail++; end
    tick();
  endtask

  task automatic test_misaligned();
    logic        ld_v[3] = '{1'b1, 1'b0, 1'b1};
    logic [1:0]  sz_v[3] = '{SZ_W, SZ_H, 2'd3};
    logic [31:0] a_v[3]  = '{32'h8000_0001, 32'h8000_0005, 32'h8000_0000};
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(ld_v[i], ~ld_v[i], sz_v[i], a_v[i], 32'hFFFF_FFFF);
      n_chk++; if ({done, err, mem_req_valid, req_ready} !== 4'b1100) begin $display("FAIL mis%0d_err: got %b want 1100", i, {done, err, mem_req_valid, req_ready}); n_fail++; end
      tick();
      n_chk++; if ({done, err, mem_req_valid, req_ready} !== 4'b0001) begin $display("FAIL mis%0d_idle: got %b want 0001", i, {done, err, mem_req_valid, req_ready}); n_fail++; end
      n_chk++; if (mem_r !== 32'h0000_1234) begin $display("FAIL mis%0d_mem_r: got %h want 00001234", i, mem_r); n_fail++; end
    end
  endtask

  task automatic test_timeout();
    int cyc;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    issue(1'b1, 1'b0, SZ_W, 32'h8000_0010, 32'h0);
    wait_done(1, cyc);
    n_chk++; if (cyc !== 6) begin $display("FAIL to_latency: got %0d want 6", cyc); n_fail++; end
    n_chk++; if (err !== 1'b1) begin $display("FAIL to_err: got %b want 1", err); n_fail++; end
    tick();
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    n_chk++; if (mem_r !== 32'h0000_1234 || done !== 1'b0) begin $display("FAIL to_late_resp: got mem_r %h done %b want 00001234 0", mem_r, done); n_fail++; end
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset_wait();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    issue(1'b1, 1'b0, SZ_W, 32'h8000_0020, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    n_chk++; if ({req_ready, done, err, mem_req_valid} !== 4'b1000) begin $display("FAIL rw_ctrl: got %b want 1000", {req_ready, done, err, mem_req_valid}); n_fail++; end
    n_chk++; if (mem_r !== 32'h0) begin $display("FAIL rw_mem_r: got %h want 00000000", mem_r); n_fail++; end
    rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h55AA_55AA;
    tick();
    n_chk++; if ({req_ready, done} !== 2'b10 || mem_r !== 32'h0) begin $display("FAIL rw_late_resp: got rdy/done %b mem_r %h want 10 00000000", {req_ready, done}, mem_r); n_fail++; end
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hAABB_CCDD;
    issue(1'b1, 1'b1, SZ_W, 32'h8000_0000, 32'h0);
    n_chk++; if ({req_ready, mem_req_valid} !== 2'b10) begin $display("FAIL both_types: got %b want 10", {req_ready, mem_req_valid}); n_fail++; end
    issue(1'b1, 1'b0, SZ_B, 32'h8000_0001, 32'h0);
    wait_done(1, cyc);
    n_chk++; if (cyc !== 3 || mem_r !== 32'h00AA_BBCC) begin $display("FAIL bl_result: got cyc %0d mem_r %h want 3 00aabbcc", cyc, mem_r); n_fail++; end
    tick();
    mem_rdata = 32'h0F0F_0F0F;
    issue(1'b1, 1'b0, SZ_W, 32'h8000_0000, 32'h0);
    wait_done(1, cyc);
    n_chk++; if (cyc !== 3 || mem_r !== 32'h0F0F_0F0F) begin $display("FAIL b2b_result: got cyc %0d mem_r %h want 3 0f0f0f0f", cyc, mem_r); n_fail++; end
    tick();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; size = 2'b00;
    addr = 32'h0; wdata = 32'h0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_word_load();
    test_store_patterns();
    test_stall_half_load();
    test_misaligned();
    test_timeout();
    test_reset_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
